manual_drive_fsm: RTL and testbench

Manual-mode driving state machine for the car. It converts the driver switch and button inputs into the one-hot car state, the `power_now` flag and the 4-bit motion command `answer` {left, right, back, forward}. The turn-signal light controller and the motor/display stages consume these outputs directly. It is active only while `module_choose` selects manual mode.

---
 rtl/manual_drive_fsm.sv | 150 +++++++++++++++
 tb/tb_manual_drive_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/manual_drive_fsm.sv
// Manual-mode driving FSM: synchronizes the driver switches, tracks power-on hold time,
// and produces the one-hot car state, power flag and registered motion command.
module manual_drive_fsm #(
    parameter int unsigned PRESS_CYCLES = 100_000_000,
    parameter logic [1:0]  MANUAL_MODE  = 2'b01
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] module_choose_i,
    input  logic       power_btn_i,
    input  logic       clutch_i,
    input  logic       throttle_i,
    input  logic       brake_i,
    input  logic       reverse_i,
    input  logic       turn_left_i,
    input  logic       turn_right_i,
    output logic       power_now_o,
    output logic [3:0] state_o,
    output logic [3:0] answer_o
);

    localparam int unsigned CNT_W = (PRESS_CYCLES > 1) ? $clog2(PRESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESS_CYCLES - 1);

    localparam logic [3:0] S_NOT_STARTED = 4'b0001;
    localparam logic [3:0] S_STARTING    = 4'b0010;
    localparam logic [3:0] S_MOVING      = 4'b0100;
    localparam logic [3:0] S_OFF         = 4'b1000;

    logic [6:0]       sync1_q;
    logic [6:0]       sync2_q;
    logic             pwr_prev_q;
    logic             rev_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic             power_now_q;
    logic [3:0]       answer_q;
    logic [3:0]       answer_d;

    logic power_btn_s;
    logic clutch_s;
    logic throttle_s;
    logic brake_s;
    logic reverse_s;
    logic turn_left_s;
    logic turn_right_s;
    logic manual;
    logic pwr_rise;
    logic rev_chg;

    assign power_btn_s  = sync2_q[0];
    assign clutch_s     = sync2_q[1];
    assign throttle_s   = sync2_q[2];
    assign brake_s      = sync2_q[3];
    assign reverse_s    = sync2_q[4];
    assign turn_left_s  = sync2_q[5];
    assign turn_right_s = sync2_q[6];

    assign manual   = (module_choose_i == MANUAL_MODE);
    assign pwr_rise = power_btn_s & ~pwr_prev_q;
    assign rev_chg  = reverse_s ^ rev_prev_q;

    // Synchronizers and edge history run regardless of mode so stale edges never fire later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            pwr_prev_q <= 1'b0;
            rev_prev_q <= 1'b0;
        end else begin
            sync1_q    <= {turn_right_i, turn_left_i, reverse_i, brake_i,
                           throttle_i, clutch_i, power_btn_i};
            sync2_q    <= sync1_q;
            pwr_prev_q <= power_btn_s;
            rev_prev_q <= reverse_s;
        end
    end

    always_comb begin
        cnt_d = '0;
        if (manual && (state_q == S_OFF) && power_btn_s && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (manual) begin
            case (state_q)
                S_OFF: begin
                    if (power_btn_s && (cnt_q == CNT_LAST)) state_d = S_NOT_STARTED;
                end
                S_NOT_STARTED: begin
                    if (pwr_rise)                     state_d = S_OFF;
                    else if (brake_s)                 state_d = S_NOT_STARTED;
                    else if (throttle_s && clutch_s)  state_d = S_STARTING;
                    else if (throttle_s && !clutch_s) state_d = S_OFF;
                end
                S_STARTING: begin
                    if (pwr_rise)                     state_d = S_OFF;
                    else if (brake_s)                 state_d = S_NOT_STARTED;
                    else if (throttle_s && !clutch_s) state_d = S_MOVING;
                end
                S_MOVING: begin
                    if (pwr_rise)                     state_d = S_OFF;
                    else if (brake_s)                 state_d = S_NOT_STARTED;
                    else if (rev_chg && !clutch_s)    state_d = S_OFF;
                    else if (clutch_s || !throttle_s) state_d = S_STARTING;
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    // Motion command is derived from the registered state, so it trails state by one cycle.
    always_comb begin
        logic moving;
        logic driving;
        moving   = (state_q == S_MOVING);
        driving  = moving || (state_q == S_STARTING);
        answer_d = 4'b0000;
        if (manual) begin
            answer_d[0] = moving & ~reverse_s;
            answer_d[1] = moving & reverse_s;
            answer_d[2] = driving & turn_right_s & ~turn_left_s;
            answer_d[3] = driving & turn_left_s & ~turn_right_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            state_q     <= S_OFF;
            power_now_q <= 1'b0;
            answer_q    <= 4'b0000;
        end else begin
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            power_now_q <= ~state_d[3];
            answer_q    <= answer_d;
        end
    end

    assign state_o     = state_q;
    assign power_now_o = power_now_q;
    assign answer_o    = answer_q;

endmodule

// File: tb/tb_manual_drive_fsm.sv
// Scoreboard bench for manual_drive_fsm: directed driver scenarios push expected
// outputs into a queue that a negedge monitor drains and compares.
module tb_manual_drive_fsm;

    localparam logic [3:0] ST_NS  = 4'b0001;
    localparam logic [3:0] ST_STG = 4'b0010;
    localparam logic [3:0] ST_MOV = 4'b0100;
    localparam logic [3:0] ST_OFF = 4'b1000;

    typedef struct {
        string      name;
        logic [3:0] st;
        logic       pw;
        logic [3:0] ans;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b01;
    logic       pwr = 1'b0, clutch = 1'b0, thr = 1'b0, brake = 1'b0;
    logic       rev = 1'b0, tl = 1'b0, tr = 1'b0;
    logic       power_now;
    logic [3:0] state;
    logic [3:0] answer;

    exp_t expQ[$];
    int   assertCount = 0;
    int   failCount   = 0;

    manual_drive_fsm #(.PRESS_CYCLES(8), .MANUAL_MODE(2'b01)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .module_choose_i (mode),
        .power_btn_i     (pwr),
        .clutch_i        (clutch),
        .throttle_i      (thr),
        .brake_i         (brake),
        .reverse_i       (rev),
        .turn_left_i     (tl),
        .turn_right_i    (tr),
        .power_now_o     (power_now),
        .state_o         (state),
        .answer_o        (answer)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: outputs are registered, so every expectation queued during the high phase is checked at the negedge.
    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            assertCount++;
            if (state !== e.st) begin
                failCount++;
                $display("[TB] FAIL %s state: got %b expected %b", e.name, state, e.st);
            end
            assertCount++;
            if (power_now !== e.pw) begin
                failCount++;
                $display("[TB] FAIL %s power_now: got %b expected %b", e.name, power_now, e.pw);
            end
            assertCount++;
            if (answer !== e.ans) begin
                failCount++;
                $display("[TB] FAIL %s answer: got %b expected %b", e.name, answer, e.ans);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] st,
                               input logic pw, input logic [3:0] ans);
        exp_t e;
        e.name = name;
        e.st   = st;
        e.pw   = pw;
        e.ans  = ans;
        expQ.push_back(e);
    endtask

    task automatic powerOn();
        pwr = 1'b1;
        step(10);
        checkOutput("power_on_seq", ST_NS, 1'b1, 4'b0000);
        pwr = 1'b0;
        step(3);
    endtask

    task automatic applyStimulus();
        step(2);
        checkOutput("reset", ST_OFF, 1'b0, 4'b0000);
        rst = 1'b0;

        pwr = 1'b1; step(7); pwr = 1'b0; step(5);
        checkOutput("short_press", ST_OFF, 1'b0, 4'b0000);
        pwr = 1'b1; step(9);
        checkOutput("press_minus1", ST_OFF, 1'b0, 4'b0000);
        step(1);
        checkOutput("power_on", ST_NS, 1'b1, 4'b0000);
        pwr = 1'b0; step(4);
        checkOutput("release_stays_on", ST_NS, 1'b1, 4'b0000);
        pwr = 1'b1; step(2);
        checkOutput("rise_latency", ST_NS, 1'b1, 4'b0000);
        step(1);
        checkOutput("rise_power_off", ST_OFF, 1'b0, 4'b0000);
        pwr = 1'b0; step(4);

        powerOn();
        clutch = 1'b1; thr = 1'b1; step(3);
        checkOutput("start", ST_STG, 1'b1, 4'b0000);
        clutch = 1'b0; step(3);
        checkOutput("move_answer_lag", ST_MOV, 1'b1, 4'b0000);
        step(1);
        checkOutput("forward", ST_MOV, 1'b1, 4'b0001);
        rev = 1'b1; clutch = 1'b1; step(3);
        checkOutput("reverse_with_clutch", ST_STG, 1'b1, 4'b0010);
        step(1);
        checkOutput("starting_answer", ST_STG, 1'b1, 4'b0000);
        clutch = 1'b0; step(3);
        checkOutput("move_back_lag", ST_MOV, 1'b1, 4'b0000);
        step(1);
        checkOutput("back", ST_MOV, 1'b1, 4'b0010);

        rev = 1'b0; step(3);
        checkOutput("gear_no_clutch", ST_OFF, 1'b0, 4'b0001);
        step(1);
        checkOutput("gear_off_answer", ST_OFF, 1'b0, 4'b0000);
        thr = 1'b0; step(3);
        powerOn();
        thr = 1'b1; step(2);
        checkOutput("stall_latency", ST_NS, 1'b1, 4'b0000);
        step(1);
        checkOutput("stall", ST_OFF, 1'b0, 4'b0000);

        thr = 1'b0; step(3);
        powerOn();
        clutch = 1'b1; thr = 1'b1; step(3);
        checkOutput("start2", ST_STG, 1'b1, 4'b0000);
        clutch = 1'b0; step(4);
        checkOutput("forward2", ST_MOV, 1'b1, 4'b0001);
        tl = 1'b1; step(2);
        checkOutput("left_latency", ST_MOV, 1'b1, 4'b0001);
        step(1);
        checkOutput("left", ST_MOV, 1'b1, 4'b1001);
        tr = 1'b1; step(3);
        checkOutput("both_turns", ST_MOV, 1'b1, 4'b0001);
        brake = 1'b1; step(3);
        checkOutput("brake", ST_NS, 1'b1, 4'b0001);
        step(1);
        checkOutput("brake_answer", ST_NS, 1'b1, 4'b0000);
        pwr = 1'b1; step(3);
        checkOutput("rise_with_brake", ST_OFF, 1'b0, 4'b0000);
        pwr = 1'b0; brake = 1'b0; thr = 1'b0; tl = 1'b0; tr = 1'b0; step(4);

        powerOn();
        clutch = 1'b1; thr = 1'b1; step(3);
        clutch = 1'b0; step(4);
        checkOutput("forward3", ST_MOV, 1'b1, 4'b0001);
        mode = 2'b10; step(1);
        checkOutput("nonmanual_answer", ST_MOV, 1'b1, 4'b0000);
        brake = 1'b1; pwr = 1'b1; rev = 1'b1; clutch = 1'b1; thr = 1'b0; tl = 1'b1;
        step(4);
        pwr = 1'b0; step(4);
        checkOutput("nonmanual_hold", ST_MOV, 1'b1, 4'b0000);
        brake = 1'b0; clutch = 1'b0; thr = 1'b1; tl = 1'b0; step(4);
        mode = 2'b01; step(1);
        checkOutput("manual_restore", ST_MOV, 1'b1, 4'b0010);

        rst = 1'b1; step(1);
        checkOutput("mid_reset", ST_OFF, 1'b0, 4'b0000);
        rst = 1'b0; thr = 1'b0; rev = 1'b0; step(3);
        pwr = 1'b1; step(9);
        checkOutput("post_reset_minus1", ST_OFF, 1'b0, 4'b0000);
        step(1);
        checkOutput("post_reset_power_on", ST_NS, 1'b1, 4'b0000);
        pwr = 1'b0; step(2);
    endtask

    initial begin
        applyStimulus();
        for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: got %0d pending expectations expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
